// File: rtl/ccc_lock_reset_ctrl.sv
// Reset sequencer behind the fabric CCC: synchronises LOCK, qualifies it for a
// stable window, holds fabric reset for a further window, then releases.
module ccc_lock_reset_ctrl #(
  parameter int SYNC_STAGES        = 2,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int RESET_HOLD_CYCLES  = 16
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       LOCK,
  input  logic       SW_RST_REQ,
  output logic       SYS_RESET,
  output logic       READY,
  output logic [1:0] STATE,
  output logic [7:0] LOCK_LOST_CNT
);

  localparam int MAX_CYC = (LOCK_STABLE_CYCLES > RESET_HOLD_CYCLES) ?
                           LOCK_STABLE_CYCLES : RESET_HOLD_CYCLES;
  localparam int CW      = $clog2(MAX_CYC) + 1;

  localparam logic [CW-1:0] CNT_ZERO    = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE     = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] STABLE_LAST = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST   = CW'(RESET_HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_STABLE    = 2'd1,
    ST_HOLD      = 2'd2,
    ST_RUN       = 2'd3
  } state_t;

  state_t                 state_r, state_s;
  logic [CW-1:0]          cnt_r, cnt_s;
  logic [SYNC_STAGES-1:0] sync_r;
  logic                   lock_s;
  logic                   lost_s;
  logic                   sys_reset_r;
  logic                   ready_r;
  logic [7:0]             lost_cnt_r;

  assign lock_s = sync_r[SYNC_STAGES-1];

  // Next-state and counter logic; any lock drop restarts qualification.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    lost_s  = 1'b0;
    case (state_r)
      ST_WAIT_LOCK: begin
        cnt_s = CNT_ZERO;
        if (lock_s) begin
          state_s = ST_STABLE;
        end else begin
          state_s = ST_WAIT_LOCK;
        end
      end
      ST_STABLE: begin
        if (!lock_s) begin
          state_s = ST_WAIT_LOCK;
          cnt_s   = CNT_ZERO;
        end else if (cnt_r == STABLE_LAST) begin
          state_s = ST_HOLD;
          cnt_s   = CNT_ZERO;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      ST_HOLD: begin
        if (!lock_s) begin
          state_s = ST_WAIT_LOCK;
          cnt_s   = CNT_ZERO;
        end else if (cnt_r == HOLD_LAST) begin
          state_s = ST_RUN;
          cnt_s   = CNT_ZERO;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      ST_RUN: begin
        // Lock loss wins over a coincident software request.
        if (!lock_s) begin
          state_s = ST_WAIT_LOCK;
          cnt_s   = CNT_ZERO;
          lost_s  = 1'b1;
        end else if (SW_RST_REQ) begin
          state_s = ST_HOLD;
          cnt_s   = CNT_ZERO;
        end else begin
          state_s = ST_RUN;
        end
      end
      default: begin
        state_s = ST_WAIT_LOCK;
        cnt_s   = CNT_ZERO;
      end
    endcase
  end

  // State, synchroniser and registered outputs; RESET overrides everything.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync_r      <= {SYNC_STAGES{1'b0}};
      state_r     <= ST_WAIT_LOCK;
      cnt_r       <= CNT_ZERO;
      sys_reset_r <= 1'b1;
      ready_r     <= 1'b0;
      lost_cnt_r  <= 8'd0;
    end else begin
      sync_r      <= {sync_r[SYNC_STAGES-2:0], LOCK};
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      sys_reset_r <= (state_s != ST_RUN);
      ready_r     <= (state_s == ST_RUN);
      if (lost_s && (lost_cnt_r != 8'hFF)) begin
        lost_cnt_r <= lost_cnt_r + 8'd1;
      end
    end
  end

  assign SYS_RESET     = sys_reset_r;
  assign READY         = ready_r;
  assign STATE         = state_r;
  assign LOCK_LOST_CNT = lost_cnt_r;

endmodule

// File: tb/tb_ccc_lock_reset_ctrl.sv
// Scoreboard bench for ccc_lock_reset_ctrl: stimulus queues the expected output
// transitions with their edge number; a monitor pops them as outputs change.
module tb_ccc_lock_reset_ctrl;

  localparam int S   = 2;
  localparam int L   = 8;
  localparam int H   = 4;
  localparam int ACQ = S + 1 + L + H;

  logic       CLK = 1'b0;
  logic       RESET, LOCK, SW_RST_REQ;
  logic       SYS_RESET, READY;
  logic [1:0] STATE;
  logic [7:0] LOCK_LOST_CNT;

  typedef struct {
    int          cyc;
    logic [11:0] val;
  } exp_t;

  exp_t        sbq[$];
  int          total  = 0;
  int          bad    = 0;
  int          cyc    = 0;
  int          llc_m  = 0;
  int          n_loss = 0;
  bit          mon_en = 1'b0;
  logic [11:0] prev_v;

  ccc_lock_reset_ctrl #(
    .SYNC_STAGES(S), .LOCK_STABLE_CYCLES(L), .RESET_HOLD_CYCLES(H)
  ) dut (
    .CLK(CLK), .RESET(RESET), .LOCK(LOCK), .SW_RST_REQ(SW_RST_REQ),
    .SYS_RESET(SYS_RESET), .READY(READY), .STATE(STATE),
    .LOCK_LOST_CNT(LOCK_LOST_CNT)
  );

  initial forever #5 CLK = ~CLK;
  initial forever begin @(posedge CLK); cyc = cyc + 1; end

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1, "watchdog expired");
  end

  function automatic logic [11:0] pk(logic [1:0] st, logic sr, logic [7:0] llc);
    return {st, sr, ~sr, llc};
  endfunction

  task automatic push(int c, logic [1:0] st, logic sr);
    exp_t e;
    e.cyc = c;
    e.val = pk(st, sr, 8'(llc_m));
    sbq.push_back(e);
  endtask

  task automatic wait_to(int c);
    while (cyc < c) @(negedge CLK);
  endtask

  // LOCK is set at negedge c0, so edge c0+1 samples it; SYS_RESET falls on
  // the ACQ-th edge counting that sampling edge as the first.
  task automatic push_acq(int c0);
    push(c0 + S + 1,         2'd1, 1'b1);
    push(c0 + S + 1 + L,     2'd2, 1'b1);
    push(c0 + S + 1 + L + H, 2'd3, 1'b0);
  endtask

  task automatic acquire();
    int c0;
    c0 = cyc;
    LOCK = 1'b1;
    push_acq(c0);
    wait_to(c0 + ACQ + 1);
  endtask

  task automatic lose(bit with_sw);
    int c0;
    c0 = cyc;
    LOCK = 1'b0;
    n_loss++;
    if (llc_m < 255) llc_m++;
    push(c0 + S + 1, 2'd0, 1'b1);
    if (with_sw) begin
      wait_to(c0 + S);
      SW_RST_REQ = 1'b1;
      @(negedge CLK);
      SW_RST_REQ = 1'b0;
    end
    wait_to(c0 + S + 1);
  endtask

  task automatic sw_run();
    int c0;
    c0 = cyc;
    SW_RST_REQ = 1'b1;
    push(c0 + 1,     2'd2, 1'b1);
    push(c0 + 1 + H, 2'd3, 1'b0);
    @(negedge CLK);
    SW_RST_REQ = 1'b0;
    wait_to(c0 + H + 3);
  endtask

  // LOCK low for one cycle so the FSM sees lock_s=0 while STABLE cnt=5.
  task automatic glitch();
    int c0;
    c0 = cyc;
    LOCK = 1'b1;
    push(c0 + S + 1, 2'd1, 1'b1);
    wait_to(c0 + 6);
    LOCK = 1'b0;
    push(c0 + S + 7, 2'd0, 1'b1);
    @(negedge CLK);
    LOCK = 1'b1;
    push_acq(c0 + 7);
    wait_to(c0 + 7 + ACQ + 1);
  endtask

  task automatic sw_hold();
    int c0;
    c0 = cyc;
    LOCK = 1'b1;
    push_acq(c0);
    wait_to(c0 + S + 2 + L);
    SW_RST_REQ = 1'b1;
    @(negedge CLK);
    SW_RST_REQ = 1'b0;
    wait_to(c0 + ACQ + 6);
  endtask

  task automatic reset_hold();
    int c0;
    c0 = cyc;
    SW_RST_REQ = 1'b1;
    push(c0 + 1, 2'd2, 1'b1);
    @(negedge CLK);
    SW_RST_REQ = 1'b0;
    RESET = 1'b1;
    llc_m = 0;
    push(c0 + 2, 2'd0, 1'b1);
    @(negedge CLK);
    RESET = 1'b0;
    push_acq(c0 + 2);
    wait_to(c0 + 2 + ACQ + 1);
  endtask

  // Monitor: compares each output change against the head of the scoreboard.
  initial begin
    logic [11:0] cur;
    exp_t        e;
    forever begin
      @(negedge CLK);
      if (mon_en) begin
        cur = {STATE, SYS_RESET, READY, LOCK_LOST_CNT};
        total++;
        if (READY !== ~SYS_RESET) begin
          bad++;
          $display("FAIL ready_inv cyc=%0d actual READY=%b required=%b", cyc, READY, ~SYS_RESET);
        end
        if (sbq.size() > 0 && cyc > sbq[0].cyc && cur === prev_v) begin
          e = sbq.pop_front();
          total++;
          bad++;
          $display("FAIL missing_evt cyc=%0d actual=none required=%h@%0d", cyc, e.val, e.cyc);
        end
        if (cur !== prev_v) begin
          total++;
          if (sbq.size() == 0) begin
            bad++;
            $display("FAIL unexpected_evt cyc=%0d actual=%h required=none", cyc, cur);
          end else begin
            e = sbq.pop_front();
            if (e.cyc != cyc || e.val !== cur) begin
              bad++;
              $display("FAIL evt actual=%h@%0d required=%h@%0d", cur, cyc, e.val, e.cyc);
            end
          end
          prev_v = cur;
        end
      end
    end
  end

  initial begin
    RESET = 1'b1;
    LOCK = 1'b1;
    SW_RST_REQ = 1'b0;
    repeat (3) begin
      @(negedge CLK);
      total++;
      if ({STATE, SYS_RESET, READY, LOCK_LOST_CNT} !== pk(2'd0, 1'b1, 8'd0)) begin
        bad++;
        $display("FAIL reset_state cyc=%0d actual=%h required=%h", cyc,
                 {STATE, SYS_RESET, READY, LOCK_LOST_CNT}, pk(2'd0, 1'b1, 8'd0));
      end
    end
    RESET = 1'b0;
    LOCK = 1'b0;
    prev_v = pk(2'd0, 1'b1, 8'd0);
    mon_en = 1'b1;
    repeat (3) @(negedge CLK);

    acquire();
    sw_run();
    lose(1'b0);
    acquire();
    lose(1'b1);
    acquire();
    lose(1'b0);
    glitch();
    lose(1'b0);
    sw_hold();
    while (n_loss < 300) begin
      lose(1'b0);
      acquire();
    end
    reset_hold();

    for (int i = 0; i < 50 && sbq.size() > 0; i++) @(negedge CLK);
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL drain actual=%0d pending required=0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
